// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the fetch unit: FSM states, next-PC select codes and
// the opcodes the fetch path needs to recognise.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;

  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_J    = 4'b1110;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
// Bundle of control-unit, extend-unit and instruction-memory signals seen by
// the fetch unit. The master side is the fetch unit itself.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;

  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] ExtImm;
  logic [31:0] ImemData;
  logic [31:0] ImemAddr;
  logic [31:0] curPC;
  logic [31:0] nextPC;
  logic [31:0] Instr;
  logic [3:0]  opcode;
  logic        InsValid;
  logic        Halted;
  logic [31:0] RetireCnt;

  modport master (
    input  PCWre, PCSrc, ExtImm, ImemData,
    output ImemAddr, curPC, nextPC, Instr, opcode, InsValid, Halted, RetireCnt
  );

  modport slave (
    output PCWre, PCSrc, ExtImm, ImemData,
    input  ImemAddr, curPC, nextPC, Instr, opcode, InsValid, Halted, RetireCnt
  );

endinterface

`default_nettype wire

// File: rtl/next_pc_mux.sv
// ----------------------------------------------------------------------------
// next_pc_mux
// Purely combinational next-PC selection: sequential, PC-relative branch or
// pseudo-direct jump. All arithmetic wraps modulo 2^32.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] cur_pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] ext_imm,
  input  logic [25:0] instr_index,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = cur_pc + 32'd4;

  // Select the candidate address; the reserved code falls back to PC+4.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PCSRC_SEQ:    next_pc = pc_plus4;
      PCSRC_BRANCH: next_pc = pc_plus4 + (ext_imm << 2);
      PCSRC_JUMP:   next_pc = {pc_plus4[31:28], instr_index, 2'b00};
      PCSRC_RSVD:   next_pc = pc_plus4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Program counter, BOOT/RUN/HALT sequencing and retired-instruction counter.
// Instruction data is only presented while running; opcode is derived from
// the state and memory data alone, never from PCSrc/ExtImm.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset,
  fetch_unit_if.master bus
);

  state_t      state;
  state_t      state_next;
  logic [31:0] cur_pc;
  logic [31:0] pc_next;
  logic [31:0] retire_cnt;
  logic [31:0] retire_next;
  logic [31:0] mux_pc;
  logic [31:0] instr;
  logic        run;

  assign run   = (state == ST_RUN);
  assign instr = run ? bus.ImemData : 32'd0;

  next_pc_mux u_next_pc_mux (
    .cur_pc      (cur_pc),
    .pc_src      (bus.PCSrc),
    .ext_imm     (bus.ExtImm),
    .instr_index (instr[25:0]),
    .next_pc     (mux_pc)
  );

  // Next state, next PC and retire count; a halt opcode only takes effect
  // when the control unit has withheld the PC write.
  always_comb begin
    state_next  = state;
    pc_next     = cur_pc;
    retire_next = retire_cnt;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (bus.PCWre) begin
          pc_next     = mux_pc;
          retire_next = retire_cnt + 32'd1;
        end else if (instr[31:28] == OP_HALT) begin
          state_next  = ST_HALT;
          retire_next = retire_cnt + 32'd1;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_BOOT;
    endcase
  end

  // State, PC and counter registers with asynchronous clear.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_BOOT;
      cur_pc     <= 32'd0;
      retire_cnt <= 32'd0;
    end else begin
      state      <= state_next;
      cur_pc     <= pc_next;
      retire_cnt <= retire_next;
    end
  end

  assign bus.ImemAddr  = cur_pc;
  assign bus.curPC     = cur_pc;
  assign bus.nextPC    = run ? mux_pc : cur_pc;
  assign bus.Instr     = instr;
  assign bus.opcode    = instr[31:28];
  assign bus.InsValid  = run;
  assign bus.Halted    = (state == ST_HALT);
  assign bus.RetireCnt = retire_cnt;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port PCWre, input, 1 bit: PC write enable from the control unit; 0 means halt.
REQ-004 SHALL have port PCSrc, input, 2 bits: next-PC select from the control unit.
REQ-005 SHALL have port ExtImm, input, 32 bits: extended immediate from the extend unit.
REQ-006 SHALL have port ImemData, input, 32 bits: combinational instruction-memory read data at ImemAddr.
REQ-007 SHALL have port ImemAddr, output, 32 bits: byte address driven to instruction memory; equals curPC.
REQ-008 SHALL have port curPC, output, 32 bits: registered program counter.
REQ-009 SHALL have port nextPC, output, 32 bits: combinational next-PC value.
REQ-010 SHALL have port Instr, output, 32 bits: current instruction; ImemData while InsValid=1, otherwise all zeros.
REQ-011 SHALL have port opcode, output, 4 bits: Instr[31:28], feeding the control unit.
REQ-012 SHALL have port InsValid, output, 1 bit: 1 only in state RUN.
REQ-013 SHALL have port Halted, output, 1 bit: 1 only in state HALT.
REQ-014 SHALL have port RetireCnt, output, 32 bits: count of instructions retired since reset.

Function
REQ-015 SHALL implement a three-state machine with states BOOT, RUN and HALT.
REQ-016 SHALL encode PCSrc as 00 = PC+4, 01 = PC+4+(ExtImm<<2), 10 = {PC4[31:28], Instr[25:0], 2'b00}, 11 = PC+4 (reserved).
REQ-017 SHALL compute all address arithmetic modulo 2^32; carries out of bit 31 are discarded.
REQ-018 SHALL in BOOT hold curPC at 0, drive InsValid=0, Instr=0 and opcode=0, then go to RUN on the next edge without changing curPC.
REQ-019 SHALL in RUN with PCWre=1, on each edge, load curPC with nextPC and increment RetireCnt by 1.
REQ-020 SHALL in RUN with PCWre=0 and opcode=4'b1111, on the edge, go to HALT, hold curPC, and increment RetireCnt once (halt retires).
REQ-021 SHALL in RUN with PCWre=0 and any other opcode, hold curPC and RetireCnt and stay in RUN (stall).
REQ-022 SHALL in HALT hold curPC and RetireCnt, drive InsValid=0, and ignore PCWre and PCSrc; only Reset exits HALT.
REQ-023 SHALL drive nextPC = curPC in BOOT and in HALT.
REQ-024 SHALL wrap RetireCnt from 0xFFFFFFFF to 0 with no flag.
REQ-025 SHALL take a PC wrap from 0xFFFFFFFC to 0 under PCSrc=00 with no error indication.
REQ-026 SHALL carry no combinational path from PCSrc or ExtImm to opcode, so the control-unit loop stays acyclic.

Reset
REQ-027 SHALL on Reset=0 immediately, without waiting for a clock edge, force state=BOOT, curPC=0 and RetireCnt=0, giving InsValid=0, Halted=0, Instr=0 and opcode=0.
REQ-028 SHALL, when Reset is asserted mid-operation (including in HALT), discard all in-flight state; the first edge after release enters RUN at PC 0.

Structure
REQ-029 SHALL take the PCSrc encodings, the state encodings, OP_HALT=4'b1111 and OP_J=4'b1110 from a shared package, cpu_pkg.
REQ-030 SHALL place next-PC selection in one combinational sub-module, next_pc_mux, with inputs curPC, PCSrc, ExtImm and Instr[25:0]; state, PC and counter registers stay in fetch_unit.

Verification
REQ-031 SHALL be verified by this scenario: reset, release, then 3 edges with PCWre=1 and PCSrc=00 -> curPC 0 (BOOT), 0, 4, 8; RetireCnt=2.
REQ-032 SHALL be verified by this scenario: at curPC=0x10, PCSrc=01 and ExtImm=0xFFFFFFFE -> next curPC=0x0C.
REQ-033 SHALL be verified by this scenario: at curPC=0x40, PCSrc=10 and Instr[25:0]=0x000020 -> next curPC=0x80.
REQ-034 SHALL be verified by this scenario: a halt opcode at 0x14 with PCWre=0 -> Halted=1, curPC stays 0x14, RetireCnt frozen over 10 further edges, InsValid=0.
REQ-035 SHALL be verified by this scenario: Reset pulsed low between edges while in HALT -> outputs reset immediately; after release, BOOT then RUN at PC 0.
REQ-036 SHALL be verified by this scenario: RetireCnt preloaded near 0xFFFFFFFF -> wraps to 0; curPC=0xFFFFFFFC with PCSrc=00 -> curPC=0.
